pixel_rainbow_gen: RTL
======================

Name:
pixel_rainbow_gen

Overview:
- Animation source directly upstream of neopixel_control. Replaces the fixed test generator in top when a moving pattern is wanted.
- Once per frame period it emits one 32-bit word per pixel on the axi_data/axi_write_en stream that neopixel_control consumes.
- Pixels are spread around an 8-bit colour wheel. The whole wheel rotates by a fixed hue step each frame.

Parameters:
- C_RATE, 32'd50000000, axi_clock frequency in Hz.
- C_FRAME_HZ, 30, frame update rate. C_RATE/C_FRAME_HZ must be >= C_PIXELS+4.
- C_PIXELS, 12, pixels per frame, range 1..255.
- C_HUE_STEP, 4, base-hue increment per emitted frame, mod 256.
- C_BRIGHT_SHIFT, 2, right shift applied to each colour channel, range 0..7.

Ports:
- axi_clock, in, 1: sole clock.
- axi_reset, in, 1: synchronous, active-high reset.
- enable, in, 1: frames start only while high.
- axi_data, out, 32: pixel word {idx[7:0], G[7:0], R[7:0], B[7:0]}.
- axi_write_en, out, 1: one-cycle qualifier per valid axi_data word.
- busy, out, 1: high while a frame is being emitted.
- frame_count, out, 16: number of completed frames, wraps at 16'hFFFF to 0.

Behaviour:
- Clock and reset: one clock, axi_clock. Reset is synchronous and active-high on axi_reset.
- Reset values: axi_data=0, axi_write_en=0, busy=0, frame_count=0, base_hue=0, frame timer=0, state=IDLE.
- Frame timer:
  - Free-running counter 0..P-1, where P=C_RATE/C_FRAME_HZ (integer division).
  - tick=1 for the single cycle in which timer==P-1; the timer returns to 0 on the next cycle.
  - The timer runs regardless of enable and state.
- State IDLE:
  - busy=0.
  - tick && enable -> EMIT; idx:=0; hue_acc:=base_hue.
  - tick while enable=0 is ignored.
- State EMIT:
  - busy=1. Each cycle, register axi_write_en=1 and axi_data=word(idx, hue_acc).
  - Then idx+=1 and hue_acc+=SPACING (8-bit wrap), where SPACING = floor(256/C_PIXELS) truncated to 8 bits.
  - After the word with idx=C_PIXELS-1 -> DONE.
- State DONE (one cycle):
  - base_hue += C_HUE_STEP (mod 256), frame_count += 1, then -> IDLE.
- Latency: if tick is at cycle T, axi_write_en is high on cycles T+2..T+1+C_PIXELS contiguously. busy is high on T+1..T+1+C_PIXELS.
- Colour wheel, h = hue_acc, 8 bits:
  - h<85: R=255-3h, G=3h, B=0.
  - 85<=h<170, with k=h-85: R=0, G=255-3k, B=3k.
  - h>=170, with k=h-170: R=3k, G=0, B=255-3k.
  - Compute in 10-bit arithmetic, then truncate to 8 bits. Each channel is then shifted right by C_BRIGHT_SHIFT.
- Boundaries:
  - enable dropping mid-frame: the frame still completes. The stream is never truncated.
  - tick during EMIT or DONE: dropped. It is not queued and not counted.
  - axi_reset mid-frame: axi_write_en goes low on the next edge and all state returns to reset values. No partial words follow.
  - C_PIXELS=1: a single word per frame; SPACING is 0 (256 truncated to 8 bits).
- axi_data holds its last value while axi_write_en=0. Downstream must sample only when axi_write_en=1.

Test Plan:
- Reset: hold axi_reset for 5 cycles, then release with enable=0 for 3 frames -> axi_write_en never asserts, busy=0, frame_count=0.
- First frame (C_RATE=1000, C_FRAME_HZ=10, C_PIXELS=12, shift 2, enable=1):
  - Tick at cycle 99 -> 12 contiguous writes on cycles 101..112.
  - idx0=0x00003F00, idx1 (h=21)=0x010F3000, idx4 (h=84)=0x043F0000.
  - frame_count=1 after the frame.
- Rotation: second frame -> base_hue=4, idx0 word=0x00033C00 (R=243>>2=60, G=12>>2=3). After 64 frames base_hue wraps back to 0 and idx0 is again 0x00003F00.
- Mid-frame disable: drop enable on the 3rd write of a frame -> all 12 words still emitted. No further frames while enable=0; the next frame starts only after enable returns high and a tick occurs.
- Reset mid-frame: assert axi_reset on the 5th write -> axi_write_en=0 on the next cycle. After release, the first frame again starts at idx0 with base_hue=0.
- Wrap and shift: C_BRIGHT_SHIFT=0 -> idx0 word=0x0000FF00. Force frame_count to 16'hFFFF -> next frame reads 0.

Source files
------------

// File: rtl/pixel_rainbow_gen.sv
// pixel_rainbow_gen
// Rotating colour-wheel animation source for neopixel_control. Once per frame
// period it streams one 32-bit word per pixel, spreading the pixels evenly
// around an 8-bit hue wheel. The wheel advances by a fixed step every frame.
//
// Ports:
//   axi_clock    in   1  sole clock
//   axi_reset    in   1  synchronous active-high reset
//   enable       in   1  frames start only while high
//   axi_data     out 32  {idx[7:0], G[7:0], R[7:0], B[7:0]}, held between writes
//   axi_write_en out  1  one-cycle qualifier per valid axi_data word
//   busy         out  1  high while a frame is being emitted
//   frame_count  out 16  completed frames, wraps to 0 after 16'hFFFF
module pixel_rainbow_gen #(
  parameter int unsigned C_RATE         = 32'd50000000,
  parameter int unsigned C_FRAME_HZ     = 30,
  parameter int unsigned C_PIXELS       = 12,
  parameter int unsigned C_HUE_STEP     = 4,
  parameter int unsigned C_BRIGHT_SHIFT = 2
) (
  input  logic        axi_clock,
  input  logic        axi_reset,
  input  logic        enable,
  output logic [31:0] axi_data,
  output logic        axi_write_en,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned PERIOD  = C_RATE / C_FRAME_HZ;
  localparam int unsigned TIMER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD - 1);
  // 256/1 truncates to 0, so a single-pixel frame keeps one hue.
  localparam logic [7:0] SPACING  = 8'(256 / C_PIXELS);
  localparam logic [7:0] HUE_STEP = 8'(C_HUE_STEP);
  localparam logic [7:0] LAST_IDX = 8'(C_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic                tick_c;
  logic [7:0]          idx;
  logic [7:0]          hue_acc;
  logic [7:0]          base_hue;

  logic [9:0]          h10_c;
  logic [9:0]          k10_c;
  logic [9:0]          r10_c;
  logic [9:0]          g10_c;
  logic [9:0]          b10_c;
  logic [7:0]          r_c;
  logic [7:0]          g_c;
  logic [7:0]          b_c;

  // Free-running frame timer; independent of enable and of the FSM.
  assign tick_c = (timer == TIMER_LAST);

  always_ff @(posedge axi_clock) begin
    if (axi_reset) begin
      timer <= '0;
    end else if (tick_c) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Colour wheel: three linear ramps of 85 hue steps each, scaled by 3.
  always_comb begin
    h10_c = {2'b00, hue_acc};
    k10_c = '0;
    r10_c = '0;
    g10_c = '0;
    b10_c = '0;
    if (hue_acc < 8'd85) begin
      r10_c = 10'd255 - 10'd3 * h10_c;
      g10_c = 10'd3 * h10_c;
    end else if (hue_acc < 8'd170) begin
      k10_c = h10_c - 10'd85;
      g10_c = 10'd255 - 10'd3 * k10_c;
      b10_c = 10'd3 * k10_c;
    end else begin
      k10_c = h10_c - 10'd170;
      r10_c = 10'd3 * k10_c;
      b10_c = 10'd255 - 10'd3 * k10_c;
    end
    r_c = 8'(r10_c) >> C_BRIGHT_SHIFT;
    g_c = 8'(g10_c) >> C_BRIGHT_SHIFT;
    b_c = 8'(b10_c) >> C_BRIGHT_SHIFT;
  end

  // Frame sequencer: wait for tick, stream C_PIXELS words, then advance the wheel.
  always_ff @(posedge axi_clock) begin
    if (axi_reset) begin
      state        <= IDLE;
      idx          <= '0;
      hue_acc      <= '0;
      base_hue     <= '0;
      axi_data     <= '0;
      axi_write_en <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      axi_write_en <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks seen outside IDLE are simply lost.
          if (tick_c && enable) begin
            state   <= EMIT;
            idx     <= '0;
            hue_acc <= base_hue;
            busy    <= 1'b1;
          end
        end
        EMIT: begin
          // enable is not looked at here: a started frame always completes.
          axi_write_en <= 1'b1;
          axi_data     <= {idx, g_c, r_c, b_c};
          idx          <= idx + 8'd1;
          hue_acc      <= hue_acc + SPACING;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE: begin
          base_hue    <= base_hue + HUE_STEP;
          frame_count <= frame_count + 16'd1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
